// File: rtl/serial_addsub_engine.sv
// Digit-serial adder/subtractor: computes a + (mode ? ~b : b) + cin over N/D
// clock cycles, D bits per cycle, with registered sum/carry/overflow outputs.
module serial_addsub_engine #(
    parameter int N = 16,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int DIGITS = N / D;
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_q;
    logic [N-1:0]   a_sh_q;
    logic [N-1:0]   b_sh_q;
    logic [N-1:0]   sum_sh_q;
    logic           carry_q;
    logic [CW-1:0]  cnt_q;
    logic           a_msb_q;
    logic           bp_msb_q;
    logic           busy_q;
    logic           done_q;
    logic [N-1:0]   sum_q;
    logic           cout_q;
    logic           ovf_q;

    logic [N-1:0]   b_eff;
    logic [D:0]     digit_sum_d;
    logic [N-1:0]   sum_sh_d;

    // NOTE: every signal written here gets an unconditional value, so no latch can be inferred.
    always_comb begin
        b_eff       = mode ? ~b : b;
        digit_sum_d = {1'b0, a_sh_q[D-1:0]} + {1'b0, b_sh_q[D-1:0]} + (D+1)'(carry_q);
        // New digit enters at the MSB end; after N/D digits the LSB digit sits at bit 0.
        sum_sh_d    = (sum_sh_q >> D) | (N'(digit_sum_d[D-1:0]) << (N - D));
    end

    // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            bp_msb_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q   <= a;
                        b_sh_q   <= b_eff;
                        a_msb_q  <= a[N-1];
                        bp_msb_q <= b_eff[N-1];
                        carry_q  <= cin;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q   <= a_sh_q >> D;
                    b_sh_q   <= b_sh_q >> D;
                    sum_sh_q <= sum_sh_d;
                    carry_q  <= digit_sum_d[D];
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        sum_q   <= sum_sh_d;
                        cout_q  <= digit_sum_d[D];
                        ovf_q   <= (a_msb_q == bp_msb_q) && (sum_sh_d[N-1] != a_msb_q);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub_engine.sv
// Scoreboard bench for serial_addsub_engine: one D=1 and one D=4 instance,
// directed vectors pushed as expectations, monitors pop on each done pulse.
module tb_serial_addsub_engine;

    localparam int N = 16;

    typedef struct {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
        int           st;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    logic         start1 = 1'b0, mode1 = 1'b0, cin1 = 1'b0;
    logic [N-1:0] a1 = '0, b1 = '0;
    logic         busy1, done1, cout1, ovf1;
    logic [N-1:0] sum1;

    logic         start4 = 1'b0, mode4 = 1'b0, cin4 = 1'b0;
    logic [N-1:0] a4 = '0, b4 = '0;
    logic         busy4, done4, cout4, ovf4;
    logic [N-1:0] sum4;

    exp_t q1[$];
    exp_t q4[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_addsub_engine #(.N(N), .D(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    serial_addsub_engine #(.N(N), .D(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop and compare on done; sum must not move while busy.
    logic [N-1:0] prev1 = '0, prev4 = '0;
    int           bcnt1 = 0, bcnt4 = 0;

    always @(negedge clk) begin
        exp_t e;
        if (done1) begin
            if (q1.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL d1 unexpected done at cycle %0d", cyc);
            end else begin
                e = q1.pop_front();
                check("d1 sum", 32'(sum1), 32'(e.sum));
                check("d1 cout", 32'(cout1), 32'(e.cout));
                check("d1 ovf", 32'(ovf1), 32'(e.ovf));
                check("d1 latency", 32'(cyc - e.st), 32'd16);
                check("d1 busy cycles", 32'(bcnt1), 32'd16);
                check("d1 busy in done cycle", 32'(busy1), 32'd0);
            end
        end
        if (busy1) begin
            check("d1 sum hold", 32'(sum1), 32'(prev1));
            bcnt1++;
        end else begin
            bcnt1 = 0;
        end
        prev1 = sum1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (done4) begin
            if (q4.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL d4 unexpected done at cycle %0d", cyc);
            end else begin
                e = q4.pop_front();
                check("d4 sum", 32'(sum4), 32'(e.sum));
                check("d4 cout", 32'(cout4), 32'(e.cout));
                check("d4 ovf", 32'(ovf4), 32'(e.ovf));
                check("d4 latency", 32'(cyc - e.st), 32'd4);
                check("d4 busy cycles", 32'(bcnt4), 32'd4);
            end
        end
        if (busy4) begin
            check("d4 sum hold", 32'(sum4), 32'(prev4));
            bcnt4++;
        end else begin
            bcnt4 = 0;
        end
        prev4 = sum4;
    end

    task automatic wait_done1(input string name);
        int k = 0;
        while (!done1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!done1) begin
            n_cmp++; n_err++;
            $display("FAIL %s: done1 timeout after %0d cycles", name, k);
        end
    endtask

    task automatic wait_done4(input string name);
        int k = 0;
        while (!done4 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!done4) begin
            n_cmp++; n_err++;
            $display("FAIL %s: done4 timeout after %0d cycles", name, k);
        end
    endtask

    // Launch on dut1 and wait for completion; expectation pushed with the start edge cycle.
    task automatic op1(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic c, input logic m,
                       input logic [N-1:0] es, input logic ec, input logic eo);
        @(negedge clk);
        a1 = a; b1 = b; cin1 = c; mode1 = m; start1 = 1'b1;
        q1.push_back('{sum: es, cout: ec, ovf: eo, st: cyc + 1});
        @(negedge clk);
        start1 = 1'b0;
        wait_done1(name);
    endtask

    task automatic op4(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic c, input logic m,
                       input logic [N-1:0] es, input logic ec, input logic eo);
        @(negedge clk);
        a4 = a; b4 = b; cin4 = c; mode4 = m; start4 = 1'b1;
        q4.push_back('{sum: es, cout: ec, ovf: eo, st: cyc + 1});
        @(negedge clk);
        start4 = 1'b0;
        wait_done4(name);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset busy", 32'(busy1), 32'd0);
        check("reset done", 32'(done1), 32'd0);
        check("reset sum", 32'(sum1), 32'd0);
        check("reset cout", 32'(cout1), 32'd0);
        check("reset ovf", 32'(ovf1), 32'd0);
        check("reset busy4", 32'(busy4), 32'd0);

        // D=1 directed vectors
        op1("add 101+108", 16'd101, 16'd108, 1'b0, 1'b0, 16'd209, 1'b0, 1'b0);
        op1("add ffff+1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        op1("add 7fff+1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        op1("sub 5-7", 16'd5, 16'd7, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op1("sub 8000-1", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        op1("sub 10-3-1", 16'd10, 16'd3, 1'b0, 1'b1, 16'd6, 1'b1, 1'b0);

        // Start and input changes during RUN are ignored.
        @(negedge clk);
        a1 = 16'h1234; b1 = 16'h0001; cin1 = 1'b0; mode1 = 1'b0; start1 = 1'b1;
        q1.push_back('{sum: 16'h1235, cout: 1'b0, ovf: 1'b0, st: cyc + 1});
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        a1 = 16'hAAAA; b1 = 16'h5555; cin1 = 1'b1; mode1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done1("ignored start");
        repeat (20) @(negedge clk);

        // Reset sampled on the edge that would process digit 8.
        @(negedge clk);
        a1 = 16'h00FF; b1 = 16'h0F00; cin1 = 1'b0; mode1 = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 32'(busy1), 32'd0);
        check("abort done", 32'(done1), 32'd0);
        check("abort sum", 32'(sum1), 32'd0);
        repeat (20) @(negedge clk);
        op1("after abort 300+45", 16'd300, 16'd45, 1'b0, 1'b0, 16'd345, 1'b0, 1'b0);

        // D=4: back-to-back start in the done cycle
        @(negedge clk);
        a4 = 16'd999; b4 = 16'd1; cin4 = 1'b1; mode4 = 1'b0; start4 = 1'b1;
        q4.push_back('{sum: 16'd1001, cout: 1'b0, ovf: 1'b0, st: cyc + 1});
        @(negedge clk);
        start4 = 1'b0;
        wait_done4("d4 999+1+1");
        a4 = 16'd255; b4 = 16'd255; cin4 = 1'b0; start4 = 1'b1;
        q4.push_back('{sum: 16'd510, cout: 1'b0, ovf: 1'b0, st: cyc + 1});
        @(negedge clk);
        start4 = 1'b0;
        wait_done4("d4 255+255");

        op4("d4 8000+8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Held start relaunches every time the FSM returns to IDLE.
        @(negedge clk);
        a4 = 16'h00F0; b4 = 16'h0F0F; cin4 = 1'b0; mode4 = 1'b0; start4 = 1'b1;
        q4.push_back('{sum: 16'h0FFF, cout: 1'b0, ovf: 1'b0, st: cyc + 1});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wait_done4("d4 held start");
            if (i < 2)
                q4.push_back('{sum: 16'h0FFF, cout: 1'b0, ovf: 1'b0, st: cyc + 1});
            else
                start4 = 1'b0;
        end

        repeat (25) @(negedge clk);
        check("d1 queue drained", 32'(q1.size()), 32'd0);
        check("d4 queue drained", 32'(q4.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_addsub_engine.md
SERIAL_ADDSUB_ENGINE -- requirements
Module: serial_addsub_engine

Interface
REQ-001 SHALL have parameter N, default 16, operand/result width in bits.
REQ-002 SHALL have parameter D, default 1, digit width in bits processed per clock; N mod D == 0 and 1 <= D <= N are required.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port mode  input  1  0 = add, 1 = subtract; captured with start.
REQ-007 SHALL have port a  input  N  operand A; captured with start.
REQ-008 SHALL have port b  input  N  operand B; captured with start.
REQ-009 SHALL have port cin  input  1  carry-in; captured with start.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-012 SHALL have port sum  output  N  result.
REQ-013 SHALL have port cout  output  1  carry out of bit N-1.
REQ-014 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and RUN.
REQ-016 In IDLE with start=1 at a clock edge, SHALL capture a, b' = (mode ? ~b : b), cin, and mode; SHALL clear the digit counter; SHALL enter RUN; busy SHALL be 1 from the next cycle.
REQ-017 In RUN, each edge SHALL add the least-significant D bits of the A and B' shift registers plus the carry register; SHALL shift the D-bit digit result into the sum shift register from the MSB side; SHALL update the carry register; SHALL increment the counter.
REQ-018 Computed result SHALL be a + b' + cin modulo 2^N; mode=1 with cin=1 gives a-b, and mode=1 with cin=0 gives a-b-1.
REQ-019 On the edge processing digit N/D-1, SHALL load sum, cout (final carry) and ovf; SHALL assert done=1 for exactly the following cycle; SHALL return to IDLE with busy=0 in that same cycle.
REQ-020 Latency: done SHALL be high N/D cycles after the start edge (16 for N=16/D=1; 4 for N=16/D=4).
REQ-021 ovf SHALL equal (a[N-1] == b'[N-1]) && (sum[N-1] != a[N-1]).
REQ-022 sum, cout, and ovf SHALL hold their last values until the next completion or reset; they SHALL NOT change during RUN.
REQ-023 start while busy=1 SHALL be ignored; no queueing.
REQ-024 start asserted in the done cycle SHALL be accepted (back-to-back operations), since the FSM is in IDLE.
REQ-025 Input changes on a, b, cin, or mode during RUN SHALL NOT affect the result in progress.
REQ-026 A held start SHALL launch a new operation each time the FSM is in IDLE.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE and set busy=0, done=0, sum=0, cout=0, ovf=0; it SHALL clear the counter, carry, and shift registers.
REQ-028 rst SHALL take priority over start and over RUN progress; reset mid-operation SHALL abort with no done pulse.
REQ-029 After rst deasserts, the first start SHALL behave per REQ-016.

Verification
REQ-030 N=16, D=1: a=101, b=108, cin=0, mode=0 -> done 16 cycles after start, sum=209, cout=0, ovf=0; busy high for 16 cycles.
REQ-031 N=16, D=4: a=999, b=1, cin=1, mode=0 -> sum=1001 after 4 cycles; back-to-back start in done cycle with a=255, b=255, cin=0 -> sum=510 after 4 more cycles.
REQ-032 Boundaries: a=16'hFFFF, b=1, cin=0, mode=0 -> sum=0, cout=1, ovf=0; a=16'h7FFF, b=1 -> sum=16'h8000, cout=0, ovf=1.
REQ-033 Subtract: mode=1, cin=1, a=5, b=7 -> sum=16'hFFFE, cout=0, ovf=0; a=16'h8000, b=1 -> sum=16'h7FFF, cout=1, ovf=1.
REQ-034 Start asserted during RUN with different operands -> ignored; first result is unchanged; no extra done pulse.
REQ-035 rst asserted at digit 8 of a D=1 operation -> next cycle busy=0, done=0, sum=0; a subsequent start completes correctly.
